// File: rtl/cnt_seq_ctrl.sv
// Sequencer for a 4-bit load/enable/up-down counter: load, prescaled count strobes, terminal detect.
// Optional CNT_SEQ_CTRL_AUTORELOAD_EN: DONE reloads automatically with the latched values until abort.
module cnt_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             up,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_din,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       pre_q, pre_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             tick;
  logic             at_term;
  logic             capture;

  always_comb begin
    tick    = (state_q == RUN) && !pause && (pre_q == PRE_LAST);
    at_term = (q == term_q);
    capture = 1'b0;
    state_d = state_q;
    pre_d   = pre_q;
    init_d  = init_q;
    term_d  = term_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          capture = 1'b1;
        end
      end
      LOAD: begin
        pre_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Prescaler only advances while not paused; pause freezes the phase.
        if (!pause) begin
          pre_d = (pre_q == PRE_LAST) ? 8'd0 : pre_q + 8'd1;
        end
        if (tick && at_term) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
`ifdef CNT_SEQ_CTRL_AUTORELOAD_EN
        state_d = LOAD;
`else
        if (start) begin
          state_d = LOAD;
          capture = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start: nothing is captured and no completion is reported.
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (capture) begin
      init_d = init_val;
      term_d = term_val;
      dir_d  = up;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      init_q  <= '0;
      term_q  <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      init_q  <= init_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // The counter consumes cnt_en on the same edge, so it must stay combinational.
  assign cnt_en   = tick & ~at_term;
  assign cnt_load = (state_q == LOAD);
  assign cnt_din  = init_q;
  assign cnt_up   = dir_q;
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: two instances (DIV=4 and DIV=1), each closing the loop through a small counter.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start1, abort, pause, up;
  logic [3:0] init_v, term_v;

  logic [3:0] q4 = '0;
  logic [3:0] q1 = '0;
  logic       load4, en4, up4, busy4, done4;
  logic       load1, en1, up1, busy1, done1;
  logic [3:0] din4, din1;
  logic [1:0] st4, st1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en4_cnt = 0, en4_last = 0, en4_gap = 0, ld4_cnt = 0, done4_cnt = 0;
  int en1_cnt = 0;
  int n;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.WIDTH(4), .DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .pause(pause), .up(up),
    .init_val(init_v), .term_val(term_v), .q(q4), .cnt_load(load4), .cnt_din(din4),
    .cnt_en(en4), .cnt_up(up4), .busy(busy4), .done(done4), .state(st4)
  );

  cnt_seq_ctrl #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .pause(pause), .up(up),
    .init_val(init_v), .term_val(term_v), .q(q1), .cnt_load(load1), .cnt_din(din1),
    .cnt_en(en1), .cnt_up(up1), .busy(busy1), .done(done1), .state(st1)
  );

  // Counter datapath stand-ins: sync load, sync enable, up/down, wrap.
  always @(posedge clk) begin
    if (load4) q4 <= din4;
    else if (en4) q4 <= up4 ? q4 + 4'd1 : q4 - 4'd1;
    if (load1) q1 <= din1;
    else if (en1) q1 <= up1 ? q1 + 4'd1 : q1 - 4'd1;
  end

  always @(posedge clk) begin
    cyc++;
    if (en4) begin
      if (en4_cnt > 0) en4_gap = cyc - en4_last;
      en4_last = cyc;
      en4_cnt++;
    end
    if (load4) ld4_cnt++;
    if (done4) done4_cnt++;
    if (en1) en1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int which, input int maxc, output int cnt);
    cnt = 0;
    while ((((which == 1) ? done1 : done4) !== 1'b1) && (cnt < maxc)) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; abort = 1'b0; pause = 1'b0;
    up = 1'b1; init_v = '0; term_v = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", st4, 2'b00);
    chk("rst_cnt_en", en4, 0);
    chk("rst_cnt_load", load4, 0);
    chk("rst_cnt_din", din4, 0);
    chk("rst_cnt_up", up4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_state_div1", st1, 2'b00);
    rst_n = 1'b1;

`ifdef CNT_SEQ_CTRL_AUTORELOAD_EN
    @(negedge clk);
    start4 = 1'b1; init_v = 4'd0; term_v = 4'd2; up = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("ar_load", st4, 2'b01);
    en4_cnt = 0; ld4_cnt = 0; done4_cnt = 0;
    wait_done(4, 60, n);
    chk("ar_pass1_latency", n, 13);
    chk("ar_pass1_en", en4_cnt, 2);
    chk("ar_pass1_q", q4, 2);
    @(negedge clk);
    chk("ar_reload_state", st4, 2'b01);
    chk("ar_reload_load", load4, 1);
    chk("ar_reload_done_clr", done4, 0);
    wait_done(4, 60, n);
    chk("ar_pass2_latency", n, 13);
    chk("ar_pass2_en", en4_cnt, 4);
    chk("ar_pass2_loads", ld4_cnt, 2);
    chk("ar_pass2_dones", done4_cnt, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ar_abort_idle", st4, 2'b00);
    repeat (8) @(negedge clk);
    chk("ar_stays_idle", st4, 2'b00);
    chk("ar_final_en", en4_cnt, 4);
    chk("ar_final_dones", done4_cnt, 2);
`else
    // Up run, DIV=4: 3 -> 7
    @(negedge clk);
    start4 = 1'b1; init_v = 4'd3; term_v = 4'd7; up = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("up_load_state", st4, 2'b01);
    chk("up_load_strobe", load4, 1);
    chk("up_load_busy", busy4, 1);
    chk("up_load_din", din4, 3);
    en4_cnt = 0; ld4_cnt = 0; done4_cnt = 0;
    @(negedge clk);
    chk("up_run_state", st4, 2'b10);
    chk("up_run_load_clr", load4, 0);
    repeat (3) @(negedge clk);
    chk("up_first_tick_en", en4, 1);
    chk("up_first_tick_q", q4, 3);
    start4 = 1'b1; init_v = 4'd9; term_v = 4'd1; up = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    chk("up_start_ignored_din", din4, 3);
    chk("up_start_ignored_dir", up4, 1);
    wait_done(4, 60, n);
    chk("up_done_latency", n, 16);
    chk("up_en_count", en4_cnt, 4);
    chk("up_en_gap", en4_gap, 4);
    chk("up_final_q", q4, 7);
    chk("up_done_state", st4, 2'b11);
    chk("up_done_busy", busy4, 0);
    @(negedge clk);
    chk("up_done_pulse_clr", done4, 0);
    chk("up_done_hold", st4, 2'b11);
    chk("up_done_count", done4_cnt, 1);
    chk("up_load_count", ld4_cnt, 1);

    // Down run with wrap, DIV=1: 2 -> 14
    start1 = 1'b1; init_v = 4'd2; term_v = 4'd14; up = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    chk("dn_load_state", st1, 2'b01);
    en1_cnt = 0;
    @(negedge clk);
    chk("dn_run_state", st1, 2'b10);
    chk("dn_first_en", en1, 1);
    wait_done(1, 40, n);
    chk("dn_done_latency", n, 5);
    chk("dn_en_count", en1_cnt, 4);
    chk("dn_final_q", q1, 14);
    chk("dn_dir", up1, 0);

    // Equal values from DONE
    start4 = 1'b1; init_v = 4'd5; term_v = 4'd5; up = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("eq_load_state", st4, 2'b01);
    en4_cnt = 0;
    @(negedge clk);
    chk("eq_run_state", st4, 2'b10);
    wait_done(4, 40, n);
    chk("eq_done_latency", n, 4);
    chk("eq_en_count", en4_cnt, 0);
    chk("eq_q", q4, 5);

    // Pause mid-run
    start4 = 1'b1; init_v = 4'd0; term_v = 4'd10; up = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("pz_run_state", st4, 2'b10);
    en4_cnt = 0;
    repeat (3) @(negedge clk);
    chk("pz_first_en", en4, 1);
    @(negedge clk);
    chk("pz_q_before", q4, 1);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    chk("pz_no_en_during", en4_cnt, 1);
    chk("pz_en_low", en4, 0);
    pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("pz_pre_frozen", en4, 0);
    @(negedge clk);
    chk("pz_resume_en", en4, 1);
    @(negedge clk);
    chk("pz_gap", en4_gap, 14);
    chk("pz_en_count", en4_cnt, 2);

    // start and abort together in RUN
    start4 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort = 1'b0;
    chk("ab_state", st4, 2'b00);
    chk("ab_busy", busy4, 0);
    chk("ab_div1_idle", st1, 2'b00);

    // abort in LOAD: issued load still lands
    start4 = 1'b1; init_v = 4'd6; term_v = 4'd8; up = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("abl_load_state", st4, 2'b01);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abl_state", st4, 2'b00);
    chk("abl_q_loaded", q4, 6);

    // Asynchronous reset mid-run
    start4 = 1'b1; init_v = 4'd1; term_v = 4'd9; up = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("ar_pre_en", en4, 1);
    chk("ar_pre_dir", up4, 0);
    en4_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_state", st4, 2'b00);
    chk("arst_en", en4, 0);
    chk("arst_up", up4, 1);
    chk("arst_busy", busy4, 0);
    #19;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_en_after", en4_cnt, 0);
    chk("arst_stays_idle", st4, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
